// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage
package wb_pkg;
    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_CSR = 2'd2;
    localparam logic [1:0] SEL_PC4 = 2'd3;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic {IDLE, WAIT_MEM} state_e;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: selects the load lane and sign/zero-extends it
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    // pick the addressed lane, then extend according to the load type
    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        data   = funct3 == F3_LB  ? {{(DATA_WIDTH-8){lane_b[7]}}, lane_b} :
                 funct3 == F3_LH  ? {{(DATA_WIDTH-16){lane_h[15]}}, lane_h} :
                 funct3 == F3_LW  ? rdata :
                 funct3 == F3_LBU ? {{(DATA_WIDTH-8){1'b0}}, lane_b} :
                 funct3 == F3_LHU ? {{(DATA_WIDTH-16){1'b0}}, lane_h} :
                 '0;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with result select, load wait and retire counter
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_sel,
    input  logic                  i_rd_wen,
    input  logic [4:0]            i_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_csr_data,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4,
    input  logic [2:0]            i_ld_funct3,
    input  logic [1:0]            i_ld_offset,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rd_wen,
    output logic [4:0]            o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_wdata,
    output logic                  o_retire,
    output logic [CNT_WIDTH-1:0]  o_retire_cnt
);
    state_e                state_q;
    logic                  wen_q, rd_wen_q, retire_q;
    logic [4:0]            addr_q, rd_addr_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] rd_wdata_q, ld_data;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  waiting, accept, done_d, wen_d, park_d;
    logic [4:0]            addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    assign waiting      = state_q == WAIT_MEM;
    assign o_ready      = !waiting;
    assign accept       = i_valid && o_ready;
    assign o_rd_wen     = rd_wen_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_rd_wdata   = rd_wdata_q;
    assign o_retire     = retire_q;
    assign o_retire_cnt = cnt_q;

    wb_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .funct3(waiting ? f3_q : i_ld_funct3),
        .offset(waiting ? off_q : i_ld_offset),
        .rdata (i_mem_rdata),
        .data  (ld_data)
    );

    // decide whether an instruction completes this cycle and what it writes
    always_comb begin
        done_d  = accept ? (i_sel != SEL_MEM || i_mem_rvalid) : (waiting && i_mem_rvalid);
        park_d  = accept && i_sel == SEL_MEM && !i_mem_rvalid;
        addr_d  = waiting ? addr_q : i_rd_addr;
        wen_d   = (waiting ? wen_q : i_rd_wen) && addr_d != 5'd0;
        wdata_d = (waiting || i_sel == SEL_MEM) ? ld_data :
                  i_sel == SEL_ALU ? i_alu_result :
                  i_sel == SEL_CSR ? i_csr_data : i_pc_plus4;
    end

    // state machine, pending-load context and registered write/retire outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_wen_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
            retire_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            retire_q <= done_d;
            rd_wen_q <= done_d && wen_d;
            if (done_d) begin
                rd_addr_q  <= addr_d;
                rd_wdata_q <= wdata_d;
                cnt_q      <= cnt_q + CNT_WIDTH'(1);
            end
            if (park_d) begin
                state_q <= WAIT_MEM;
                wen_q   <= i_rd_wen;
                addr_q  <= i_rd_addr;
                f3_q    <= i_ld_funct3;
                off_q   <= i_ld_offset;
            end else if (waiting && i_mem_rvalid) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized scoreboard bench for wb_stage
`timescale 1ns/1ps
module tb_wb_stage;
    typedef struct packed {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_valid = 0, o_ready, i_rd_wen = 0, i_mem_rvalid = 0;
    logic [1:0]  i_sel = 0, i_ld_offset = 0;
    logic [4:0]  i_rd_addr = 0, o_rd_addr;
    logic [2:0]  i_ld_funct3 = 0;
    logic [31:0] i_alu_result = 0, i_csr_data = 0, i_pc_plus4 = 0, i_mem_rdata = 0, o_rd_wdata;
    logic        o_rd_wen, o_retire;
    logic [3:0]  o_retire_cnt;
    exp_t        sb[$];
    int          ntests = 0, nfail = 0, mcnt = 0;

    wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_sel(i_sel),
        .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr), .i_alu_result(i_alu_result),
        .i_csr_data(i_csr_data), .i_pc_plus4(i_pc_plus4), .i_ld_funct3(i_ld_funct3),
        .i_ld_offset(i_ld_offset), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr), .o_rd_wdata(o_rd_wdata),
        .o_retire(o_retire), .o_retire_cnt(o_retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // reference load semantics: shift the word down to the lane and extend
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: pop an expectation for every retire, track the count
    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
            sb.delete();
        end else begin
            ntests++;
            if (o_retire) begin
                mcnt++;
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_retire actual wen=%0b addr=%0d data=%h required none", o_rd_wen, o_rd_addr, o_rd_wdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({o_rd_wen, o_rd_addr, o_rd_wdata} !== e) begin
                        nfail++;
                        $display("FAIL write actual wen=%0b addr=%0d data=%h required wen=%0b addr=%0d data=%h",
                                 o_rd_wen, o_rd_addr, o_rd_wdata, e.wen, e.addr, e.data);
                    end
                end
            end else if (o_rd_wen !== 1'b0) begin
                nfail++;
                $display("FAIL idle_wen actual=%0b required=0", o_rd_wen);
            end
            ntests++;
            if (o_retire_cnt !== 4'(mcnt)) begin
                nfail++;
                $display("FAIL retire_cnt actual=%0d required=%0d", o_retire_cnt, 4'(mcnt));
            end
        end
    end

    task automatic scramble();
        i_sel        = 2'($urandom);
        i_rd_wen     = 1'($urandom);
        i_rd_addr    = 5'($urandom);
        i_ld_funct3  = 3'($urandom);
        i_ld_offset  = 2'($urandom);
        i_alu_result = $urandom;
        i_csr_data   = $urandom;
        i_pc_plus4   = $urandom;
    endtask

    task automatic do_reset(input bit inject);
        @(negedge clk);
        #1;
        rst = 1'b1;
        if (inject) begin
            scramble();
            i_valid      = 1'b1;
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        rst          = 1'b0;
        i_valid      = 1'b0;
        i_mem_rvalid = 1'b0;
        chk("rst_wen", o_rd_wen, 0);
        chk("rst_addr", o_rd_addr, 0);
        chk("rst_wdata", o_rd_wdata, 0);
        chk("rst_retire", o_retire, 0);
        chk("rst_cnt", o_retire_cnt, 0);
        chk("rst_ready", o_ready, 1);
    endtask

    task automatic issue(input logic [1:0] sel, input logic wen, input logic [4:0] rd, input logic [31:0] val,
                         input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata, input int dly);
        exp_t e;
        scramble();
        i_valid = 1'b1; i_sel = sel; i_rd_wen = wen; i_rd_addr = rd;
        i_ld_funct3 = f3; i_ld_offset = off;
        e.wen  = wen && rd != 5'd0;
        e.addr = rd;
        e.data = sel == 2'd1 ? ld_model(f3, off, rdata) : val;
        if (sel == 2'd0) i_alu_result = val;
        if (sel == 2'd2) i_csr_data = val;
        if (sel == 2'd3) i_pc_plus4 = val;
        if (sel != 2'd1) begin
            i_mem_rvalid = 1'($urandom);
            i_mem_rdata  = $urandom;
            sb.push_back(e);
        end else if (dly == 0) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rdata;
            sb.push_back(e);
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = $urandom;
        end
        @(posedge clk);
        #1;
        if (sel == 2'd1 && dly > 0) begin
            for (int k = 0; k < dly; k++) begin
                chk("wait_ready", o_ready, 0);
                chk("wait_noretire", o_retire, 0);
                scramble();
                i_valid = 1'($urandom);
                @(posedge clk);
                #1;
            end
            scramble();
            i_valid      = 1'($urandom);
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rdata;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        chk("latency_retire", o_retire, 1);
        chk("after_ready", o_ready, 1);
        i_valid      = 1'b0;
        i_mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0] f3s [8];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        do_reset(0);
        issue(2'd0, 1, 5'd5, 32'h12345678, 0, 0, 0, 0);
        issue(2'd1, 1, 5'd7, 0, 3'b000, 2'd2, 32'h0080FF00, 0);
        issue(2'd1, 1, 5'd9, 0, 3'b101, 2'd2, 32'h80010000, 3);
        issue(2'd3, 1, 5'd0, 32'h104, 0, 0, 0, 0);
        issue(2'd2, 1, 5'd31, 32'hCAFEF00D, 0, 0, 0, 0);
        // abandoned load: reset while waiting, then a stray rvalid
        i_valid = 1; i_sel = 2'd1; i_rd_wen = 1; i_rd_addr = 5'd3; i_mem_rvalid = 0;
        @(posedge clk);
        #1;
        i_valid = 0;
        chk("park_ready", o_ready, 0);
        do_reset(1);
        i_mem_rvalid = 1; i_mem_rdata = $urandom;
        @(posedge clk);
        #1;
        i_mem_rvalid = 0;
        chk("abandon_retire", o_retire, 0);
        chk("abandon_ready", o_ready, 1);
        chk("abandon_cnt", o_retire_cnt, 0);
        // wrap of the 4-bit counter
        for (int n = 0; n < 17; n++) issue(2'd0, 1, 5'(n + 1), $urandom, 0, 0, 0, 0);
        chk("wrap_cnt", o_retire_cnt, 1);
        // randomized traffic with idle gaps carrying stray rvalid
        for (int n = 0; n < 300; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom);
            issue(sel, 1'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  f3s[$urandom_range(0, 7)], 2'($urandom), $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                scramble();
                i_mem_rvalid = 1'($urandom);
                i_mem_rdata  = $urandom;
                @(posedge clk);
                #1;
                i_mem_rvalid = 0;
            end
            if (n == 150) do_reset(1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
